// File: rtl/operand_fetch_unit_if.sv
// Core-side bundle for the operand fetch unit: start request, shared memory bus and EA results.
interface operand_fetch_unit_if;
  logic        start;
  logic [2:0]  mode;
  logic [7:0]  index;
  logic        is_write;
  logic [15:0] pc_in;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rd_data;
  logic        busy;
  logic        done;
  logic [15:0] ea;
  logic [15:0] pc_next;
  logic        page_cross;

  modport master (
    output start, mode, index, is_write, pc_in, mem_rd_data,
    input  mem_addr, busy, done, ea, pc_next, page_cross
  );

  modport slave (
    input  start, mode, index, is_write, pc_in, mem_rd_data,
    output mem_addr, busy, done, ea, pc_next, page_cross
  );
endinterface

// File: rtl/operand_fetch_unit.sv
// 6502 addressing-mode sequencer: fetches operand/pointer bytes and returns EA, next PC and
// page-cross for the eight indexed and indirect modes.
module operand_fetch_unit #(
  parameter logic [15:0] ZP_BASE           = 16'h0000,
  parameter bit          INDIRECT_BUG      = 1'b1,
  parameter bit          IDX_WRITE_PENALTY = 1'b1
) (
  input logic                  clk,
  input logic                  resetn,
  operand_fetch_unit_if.slave  io_bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StOpLo  = 3'd1;
  localparam logic [2:0] StOpHi  = 3'd2;
  localparam logic [2:0] StIdx   = 3'd3;
  localparam logic [2:0] StPtrLo = 3'd4;
  localparam logic [2:0] StPtrHi = 3'd5;
  localparam logic [2:0] StFix   = 3'd6;
  localparam logic [2:0] StDone  = 3'd7;

  localparam logic [2:0] ModeImm  = 3'd0;
  localparam logic [2:0] ModeZp   = 3'd1;
  localparam logic [2:0] ModeZpx  = 3'd2;
  localparam logic [2:0] ModeAbs  = 3'd3;
  localparam logic [2:0] ModeAbsx = 3'd4;
  localparam logic [2:0] ModeInd  = 3'd5;
  localparam logic [2:0] ModeIndx = 3'd6;
  localparam logic [2:0] ModeIndy = 3'd7;

  localparam logic [7:0] ZpHi = ZP_BASE[15:8];

  logic [2:0]  r_state, w_state;
  logic [2:0]  r_mode, w_mode;
  logic [7:0]  r_index, w_index;
  logic        r_is_write, w_is_write;
  logic [15:0] r_pc, w_pc;
  logic [7:0]  r_lo, w_lo;
  logic [7:0]  r_plo, w_plo;
  logic [15:0] r_fix_ea, w_fix_ea;
  logic        r_fix_cross, w_fix_cross;
  logic [15:0] r_mem_addr, w_mem_addr;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic [15:0] r_ea, w_ea;
  logic [15:0] r_pc_next, w_pc_next;
  logic        r_page_cross, w_page_cross;

  logic        w_idle;
  logic        w_finish;
  logic        w_fin_cross;
  logic [15:0] w_fin_ea;
  logic [7:0]  w_rd;
  logic [7:0]  w_base_lo;
  logic [8:0]  w_lo_sum;
  logic [15:0] w_idx_sum;
  logic        w_take_fix;
  logic [7:0]  w_zp_p;

  assign w_idle     = (r_state == StIdle) || (r_state == StDone);
  assign w_rd       = io_bus.mem_rd_data;
  // ABSX indexes the operand word, INDY the word read through the zero-page pointer.
  assign w_base_lo  = (r_state == StOpHi) ? r_lo : r_plo;
  assign w_lo_sum   = {1'b0, w_base_lo} + {1'b0, r_index};
  assign w_idx_sum  = {w_rd, w_base_lo} + {8'h00, r_index};
  assign w_take_fix = w_lo_sum[8] | (r_is_write & IDX_WRITE_PENALTY);
  assign w_zp_p     = r_lo + r_index;

  always_comb begin
    w_state      = r_state;
    w_mode       = r_mode;
    w_index      = r_index;
    w_is_write   = r_is_write;
    w_pc         = r_pc;
    w_lo         = r_lo;
    w_plo        = r_plo;
    w_fix_ea     = r_fix_ea;
    w_fix_cross  = r_fix_cross;
    w_mem_addr   = r_mem_addr;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_ea         = r_ea;
    w_pc_next    = r_pc_next;
    w_page_cross = r_page_cross;
    w_finish     = 1'b0;
    w_fin_ea     = 16'h0000;
    w_fin_cross  = 1'b0;

    if (w_idle && io_bus.start) begin
      w_mode     = io_bus.mode;
      w_index    = io_bus.index;
      w_is_write = io_bus.is_write;
      w_pc       = io_bus.pc_in;
      w_mem_addr = io_bus.pc_in + 16'd1;
      if (io_bus.mode == ModeImm) begin
        w_finish = 1'b1;
        w_fin_ea = io_bus.pc_in + 16'd1;
      end else begin
        w_busy  = 1'b1;
        w_state = StOpLo;
      end
    end else begin
      case (r_state)
        StDone: w_state = StIdle;
        StOpLo: begin
          w_lo = w_rd;
          case (r_mode)
            ModeZp: begin
              w_finish = 1'b1;
              w_fin_ea = {ZpHi, w_rd};
            end
            ModeZpx, ModeIndx: begin
              w_mem_addr = {ZpHi, w_rd};
              w_state    = StIdx;
            end
            ModeIndy: begin
              w_mem_addr = {ZpHi, w_rd};
              w_state    = StPtrLo;
            end
            default: begin
              w_mem_addr = r_pc + 16'd2;
              w_state    = StOpHi;
            end
          endcase
        end
        StIdx: begin
          if (r_mode == ModeZpx) begin
            w_finish = 1'b1;
            w_fin_ea = {ZpHi, w_zp_p};
          end else begin
            w_lo       = w_zp_p;
            w_mem_addr = {ZpHi, w_zp_p};
            w_state    = StPtrLo;
          end
        end
        StOpHi, StPtrHi: begin
          if ((r_state == StOpHi && r_mode == ModeAbsx) ||
              (r_state == StPtrHi && r_mode == ModeIndy)) begin
            if (w_take_fix) begin
              w_mem_addr  = {w_rd, w_lo_sum[7:0]};
              w_fix_ea    = w_idx_sum;
              w_fix_cross = w_lo_sum[8];
              w_state     = StFix;
            end else begin
              w_finish    = 1'b1;
              w_fin_ea    = w_idx_sum;
              w_fin_cross = w_lo_sum[8];
            end
          end else if (r_state == StOpHi && r_mode == ModeInd) begin
            w_mem_addr = {w_rd, r_lo};
            w_state    = StPtrLo;
          end else if (r_state == StOpHi) begin
            w_finish = 1'b1;
            w_fin_ea = {w_rd, r_lo};
          end else begin
            w_finish = 1'b1;
            w_fin_ea = {w_rd, r_plo};
          end
        end
        StPtrLo: begin
          w_plo = w_rd;
          // Zero-page pointers always wrap in their page; JMP(ind) only does so with the quirk.
          if (r_mode == ModeInd && !INDIRECT_BUG) begin
            w_mem_addr = r_mem_addr + 16'd1;
          end else begin
            w_mem_addr = {r_mem_addr[15:8], r_mem_addr[7:0] + 8'd1};
          end
          w_state = StPtrHi;
        end
        StFix: begin
          w_finish    = 1'b1;
          w_fin_ea    = r_fix_ea;
          w_fin_cross = r_fix_cross;
        end
        default: w_state = StIdle;
      endcase
    end

    if (w_finish) begin
      w_state      = StDone;
      w_busy       = 1'b0;
      w_done       = 1'b1;
      w_ea         = w_fin_ea;
      w_page_cross = w_fin_cross;
      w_pc_next    = w_pc + ((w_mode == ModeAbs || w_mode == ModeAbsx || w_mode == ModeInd) ?
                             16'd3 : 16'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_mode       <= 3'd0;
      r_index      <= 8'h00;
      r_is_write   <= 1'b0;
      r_pc         <= 16'h0000;
      r_lo         <= 8'h00;
      r_plo        <= 8'h00;
      r_fix_ea     <= 16'h0000;
      r_fix_cross  <= 1'b0;
      r_mem_addr   <= 16'h0000;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_ea         <= 16'h0000;
      r_pc_next    <= 16'h0000;
      r_page_cross <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_mode       <= w_mode;
      r_index      <= w_index;
      r_is_write   <= w_is_write;
      r_pc         <= w_pc;
      r_lo         <= w_lo;
      r_plo        <= w_plo;
      r_fix_ea     <= w_fix_ea;
      r_fix_cross  <= w_fix_cross;
      r_mem_addr   <= w_mem_addr;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_ea         <= w_ea;
      r_pc_next    <= w_pc_next;
      r_page_cross <= w_page_cross;
    end
  end

  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.ea         = r_ea;
  assign io_bus.pc_next    = r_pc_next;
  assign io_bus.page_cross = r_page_cross;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Bench for operand_fetch_unit: three parameterisations share one memory and stimulus and are
// checked against a mode-by-mode reference model.
module tb_operand_fetch_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  mode;
  logic [7:0]  index;
  logic        is_write;
  logic [15:0] pc_in;
  logic [7:0]  mem [0:65535];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // dut0: defaults; dut1: full-increment JMP(ind); dut2: relocated page, no write penalty.
  operand_fetch_unit_if bus0 ();
  operand_fetch_unit_if bus1 ();
  operand_fetch_unit_if bus2 ();

  operand_fetch_unit #(.ZP_BASE(16'h0000), .INDIRECT_BUG(1'b1), .IDX_WRITE_PENALTY(1'b1))
    u_dut0 (.clk(clk), .resetn(resetn), .io_bus(bus0));
  operand_fetch_unit #(.ZP_BASE(16'h0000), .INDIRECT_BUG(1'b0), .IDX_WRITE_PENALTY(1'b1))
    u_dut1 (.clk(clk), .resetn(resetn), .io_bus(bus1));
  operand_fetch_unit #(.ZP_BASE(16'h4200), .INDIRECT_BUG(1'b1), .IDX_WRITE_PENALTY(1'b0))
    u_dut2 (.clk(clk), .resetn(resetn), .io_bus(bus2));

  assign bus0.start = start;  assign bus0.mode = mode;  assign bus0.index = index;
  assign bus0.is_write = is_write;  assign bus0.pc_in = pc_in;
  assign bus1.start = start;  assign bus1.mode = mode;  assign bus1.index = index;
  assign bus1.is_write = is_write;  assign bus1.pc_in = pc_in;
  assign bus2.start = start;  assign bus2.mode = mode;  assign bus2.index = index;
  assign bus2.is_write = is_write;  assign bus2.pc_in = pc_in;
  assign bus0.mem_rd_data = mem[bus0.mem_addr];
  assign bus1.mem_rd_data = mem[bus1.mem_addr];
  assign bus2.mem_rd_data = mem[bus2.mem_addr];

  logic [15:0] o_ea [3];
  logic [15:0] o_pcn [3];
  logic [15:0] o_maddr [3];
  logic        o_busy [3];
  logic        o_done [3];
  logic        o_pcx [3];

  assign o_ea[0] = bus0.ea;  assign o_pcn[0] = bus0.pc_next;  assign o_maddr[0] = bus0.mem_addr;
  assign o_ea[1] = bus1.ea;  assign o_pcn[1] = bus1.pc_next;  assign o_maddr[1] = bus1.mem_addr;
  assign o_ea[2] = bus2.ea;  assign o_pcn[2] = bus2.pc_next;  assign o_maddr[2] = bus2.mem_addr;
  assign o_busy[0] = bus0.busy;  assign o_done[0] = bus0.done;  assign o_pcx[0] = bus0.page_cross;
  assign o_busy[1] = bus1.busy;  assign o_done[1] = bus1.done;  assign o_pcx[1] = bus1.page_cross;
  assign o_busy[2] = bus2.busy;  assign o_done[2] = bus2.done;  assign o_pcx[2] = bus2.page_cross;

  logic [15:0] obs_ea [3];
  logic [15:0] obs_pcn [3];
  logic        obs_pcx [3];
  logic        obs_busy [3];
  int          obs_lat [3];

  logic [15:0] e_ea, e_pcn;
  logic        e_pcx;
  int          e_lat, seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: EA/latency from the addressing-mode rules, reading the shared memory directly.
  task automatic model(input int k, input logic [2:0] m, input logic [7:0] x, input logic w,
                       input logic [15:0] pc, output logic [15:0] ea, output logic [15:0] pcn,
                       output logic pcx, output int lat);
    logic [7:0]  zh, lo, hi, p, blo, bhi;
    logic [15:0] a1, a2, ptr, ptr2, base;
    logic        bug, pen;
    zh  = (k == 2) ? 8'h42 : 8'h00;
    bug = (k != 1);
    pen = (k != 2);
    a1  = pc + 16'd1;
    a2  = pc + 16'd2;
    lo  = mem[a1];
    hi  = mem[a2];
    pcx = 1'b0;
    ea  = 16'h0000;
    base = 16'h0000;
    lat = 0;
    pcn = pc + ((m == 3'd3 || m == 3'd4 || m == 3'd5) ? 16'd3 : 16'd2);
    case (m)
      3'd0: begin ea = a1; lat = 1; end
      3'd1: begin ea = {zh, lo}; lat = 2; end
      3'd2: begin p = lo + x; ea = {zh, p}; lat = 3; end
      3'd3: begin ea = {hi, lo}; lat = 3; end
      3'd4: begin base = {hi, lo}; lat = 3; end
      3'd5: begin
        ptr = {hi, lo};
        if (bug) begin p = lo + 8'd1; ptr2 = {hi, p}; end
        else ptr2 = ptr + 16'd1;
        ea  = {mem[ptr2], mem[ptr]};
        lat = 5;
      end
      3'd6: begin
        p   = lo + x;
        blo = mem[{zh, p}];
        p   = p + 8'd1;
        bhi = mem[{zh, p}];
        ea  = {bhi, blo};
        lat = 5;
      end
      default: begin
        blo  = mem[{zh, lo}];
        p    = lo + 8'd1;
        bhi  = mem[{zh, p}];
        base = {bhi, blo};
        lat  = 4;
      end
    endcase
    if (m == 3'd4 || m == 3'd7) begin
      ea  = base + {8'h00, x};
      pcx = (int'(base[7:0]) + int'(x)) > 255;
      if (pcx || (w && pen)) lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] m, input logic [7:0] x,
                        input logic w, input logic [15:0] pc);
    logic [15:0] x_ea, x_pcn;
    logic        x_pcx;
    int          x_lat, left;
    for (int k = 0; k < 3; k++) obs_lat[k] = 0;
    @(negedge clk);
    start = 1'b1; mode = m; index = x; is_write = w; pc_in = pc;
    left = 3;
    for (int e = 1; e <= 8 && left > 0; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (obs_lat[k] == 0 && o_done[k]) begin
          obs_lat[k]  = e;
          obs_ea[k]   = o_ea[k];
          obs_pcn[k]  = o_pcn[k];
          obs_pcx[k]  = o_pcx[k];
          obs_busy[k] = o_busy[k];
          left--;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      model(k, m, x, w, pc, x_ea, x_pcn, x_pcx, x_lat);
      check($sformatf("%s dut%0d latency", tag, k), obs_lat[k], x_lat);
      check($sformatf("%s dut%0d ea", tag, k), {16'h0, obs_ea[k]}, {16'h0, x_ea});
      check($sformatf("%s dut%0d pc_next", tag, k), {16'h0, obs_pcn[k]}, {16'h0, x_pcn});
      check($sformatf("%s dut%0d page_cross", tag, k), {31'h0, obs_pcx[k]}, {31'h0, x_pcx});
      check($sformatf("%s dut%0d busy@done", tag, k), {31'h0, obs_busy[k]}, 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++)
      check($sformatf("%s dut%0d done pulse", tag, k), {31'h0, o_done[k]}, 32'h0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; mode = 3'd0; index = 8'h00; is_write = 1'b0; pc_in = 16'h0000;
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset dut%0d busy", k), {31'h0, o_busy[k]}, 32'h0);
      check($sformatf("reset dut%0d done", k), {31'h0, o_done[k]}, 32'h0);
      check($sformatf("reset dut%0d ea", k), {16'h0, o_ea[k]}, 32'h0);
      check($sformatf("reset dut%0d mem_addr", k), {16'h0, o_maddr[k]}, 32'h0);
      check($sformatf("reset dut%0d pc_next", k), {16'h0, o_pcn[k]}, 32'h0);
    end
    @(negedge clk); resetn = 1'b1;

    mem[16'h0200] = 8'hB5; mem[16'h0201] = 8'hF0;
    run_op("zpx", 3'd2, 8'h20, 1'b0, 16'h0200);
    check("zpx const ea", {16'h0, obs_ea[0]}, 32'h0010);
    check("zpx const lat", obs_lat[0], 3);
    check("zpx const pc_next", {16'h0, obs_pcn[0]}, 32'h0202);

    mem[16'h0301] = 8'hF0; mem[16'h0302] = 8'h12;
    run_op("absx cross", 3'd4, 8'h20, 1'b0, 16'h0300);
    check("absx cross const ea", {16'h0, obs_ea[0]}, 32'h1310);
    check("absx cross const lat", obs_lat[0], 4);
    check("absx cross const pcx", {31'h0, obs_pcx[0]}, 32'h1);
    run_op("absx nocross", 3'd4, 8'h05, 1'b0, 16'h0300);
    check("absx nocross const ea", {16'h0, obs_ea[0]}, 32'h12F5);
    check("absx nocross const lat", obs_lat[0], 3);
    run_op("absx write", 3'd4, 8'h05, 1'b1, 16'h0300);
    check("absx write const lat", obs_lat[0], 4);
    check("absx write nopen lat", obs_lat[2], 3);

    mem[16'h0401] = 8'hFF; mem[16'h0402] = 8'h10;
    mem[16'h10FF] = 8'h34; mem[16'h1000] = 8'h12; mem[16'h1100] = 8'h56;
    run_op("ind", 3'd5, 8'h00, 1'b0, 16'h0400);
    check("ind bug const ea", {16'h0, obs_ea[0]}, 32'h1234);
    check("ind nobug const ea", {16'h0, obs_ea[1]}, 32'h5634);
    check("ind const lat", obs_lat[0], 5);
    check("ind const pc_next", {16'h0, obs_pcn[0]}, 32'h0403);

    mem[16'h0501] = 8'hFE; mem[16'h00FF] = 8'h00; mem[16'h0000] = 8'h80;
    run_op("indx", 3'd6, 8'h01, 1'b0, 16'h0500);
    check("indx wrap const ea", {16'h0, obs_ea[0]}, 32'h8000);

    mem[16'h0601] = 8'hFF; mem[16'h00FF] = 8'hFF; mem[16'h0000] = 8'h10;
    run_op("indy", 3'd7, 8'h01, 1'b0, 16'h0600);
    check("indy const ea", {16'h0, obs_ea[0]}, 32'h1100);
    check("indy const pcx", {31'h0, obs_pcx[0]}, 32'h1);
    check("indy const lat", obs_lat[0], 5);

    mem[16'h0701] = 8'h33;
    run_op("zp", 3'd1, 8'h00, 1'b0, 16'h0700);
    check("zp relocated const ea", {16'h0, obs_ea[2]}, 32'h4233);
    run_op("imm", 3'd0, 8'h00, 1'b0, 16'hFFFF);

    // Back-to-back: second start raised during the done cycle.
    @(negedge clk);
    start = 1'b1; mode = 3'd1; index = 8'h00; is_write = 1'b0; pc_in = 16'h0700;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("b2b first done", {31'h0, o_done[0]}, 32'h1);
    start = 1'b1; mode = 3'd3; pc_in = 16'h0A00;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b dut%0d mem_addr", k), {16'h0, o_maddr[k]}, 32'h0A01);
      check($sformatf("b2b dut%0d busy", k), {31'h0, o_busy[k]}, 32'h1);
    end
    seen = 0;
    for (int e = 2; e <= 6 && seen == 0; e++) begin
      @(posedge clk); #1;
      if (o_done[0]) seen = e;
    end
    model(0, 3'd3, 8'h00, 1'b0, 16'h0A00, e_ea, e_pcn, e_pcx, e_lat);
    check("b2b second latency", seen, e_lat);
    check("b2b second ea", {16'h0, o_ea[0]}, {16'h0, e_ea});
    @(posedge clk); #1;

    // Reset landing on the E2 edge of an IND operation.
    @(negedge clk);
    start = 1'b1; mode = 3'd5; pc_in = 16'h0400;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("midreset dut%0d busy", k), {31'h0, o_busy[k]}, 32'h0);
      check($sformatf("midreset dut%0d done", k), {31'h0, o_done[k]}, 32'h0);
      check($sformatf("midreset dut%0d ea", k), {16'h0, o_ea[k]}, 32'h0);
      check($sformatf("midreset dut%0d mem_addr", k), {16'h0, o_maddr[k]}, 32'h0);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midreset stays idle", {31'h0, o_busy[0]}, 32'h0);

    // start held high with new inputs while busy must not restart or alter the latched mode.
    @(negedge clk);
    start = 1'b1; mode = 3'd3; index = 8'h00; is_write = 1'b0; pc_in = 16'h0800;
    @(posedge clk); #1;
    mode = 3'd0; pc_in = 16'h9000;
    @(posedge clk); #1;
    check("busy start no done E1", {31'h0, o_done[0]}, 32'h0);
    @(posedge clk); #1;
    start = 1'b0;
    model(0, 3'd3, 8'h00, 1'b0, 16'h0800, e_ea, e_pcn, e_pcx, e_lat);
    check("busy start done E2", {31'h0, o_done[0]}, 32'h1);
    check("busy start ea", {16'h0, o_ea[0]}, {16'h0, e_ea});
    check("busy start pc_next", {16'h0, o_pcn[0]}, 32'h0803);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 4; j++) mem[16'($urandom)] = 8'($urandom);
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), 8'($urandom),
             1'($urandom_range(0, 1)), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch_unit.md
Name: operand_fetch_unit

Overview:
- Parametrised addressing-mode sequencer for the 6502 core.
- Replaces the hard-coded ABS_n operand states with one engine that covers all eight indexed and indirect modes.
- The core issues a start after FETCH/DECODE. The unit reads operand and pointer bytes over the shared memory bus, then returns the effective address (EA), the next PC and a page-cross flag.
- ALU, register writeback and the data access itself stay in the core.

Parameters:
ZP_BASE, 16'h0000, base of the zero/direct page; ZP-class addresses are ZP_BASE + 8-bit offset (high byte replaced).
INDIRECT_BUG, 1, 1 = NMOS JMP(ind) quirk: the pointer high-byte fetch wraps within the pointer's page; 0 = full 16-bit increment.
IDX_WRITE_PENALTY, 1, 1 = ABSX/INDY with is_write always take the fix-up cycle.

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
start  in  1  request; sampled only while busy=0
mode  in  3  0 IMM, 1 ZP, 2 ZPX, 3 ABS, 4 ABSX, 5 IND, 6 INDX, 7 INDY
index  in  8  X or Y value; used by ZPX/ABSX/INDX/INDY
is_write  in  1  instruction stores to EA
pc_in  in  16  opcode address
mem_addr  out  16  registered bus address
mem_rd_data  in  8  combinational read of mem_addr; sampled at the edge ending the cycle
busy  out  1  operation in progress
done  out  1  one-cycle pulse; ea/pc_next/page_cross valid, held until next start
ea  out  16  effective address
pc_next  out  16  address of next opcode
page_cross  out  1  indexed add carried into high byte

Behaviour:
- Reset: all outputs 0; state IDLE. Reset mid-operation aborts immediately, with no done pulse.
- Start acceptance:
  - An edge with busy=0 and start=1 latches mode, index, is_write and pc_in.
  - It sets busy=1 and mem_addr=pc_in+1.
  - start while busy=1 is ignored.
- done and busy:
  - busy drops in the same cycle done rises.
  - start in the done cycle is accepted, giving back-to-back operation.
- pc_next:
  - pc_in+2 for IMM/ZP/ZPX/INDX/INDY.
  - pc_in+3 for ABS/ABSX/IND.
  - Computed mod 2^16.
- Latency L = edges from the accepting edge (inclusive) to the edge raising done.
- Per-mode sequence (each numbered edge follows the accepting edge E0):
  - IMM:
    - No read; ea=pc_in+1; L=1.
  - ZP:
    - E1 samples lo; ea=ZP_BASE|lo; L=2.
  - ZPX:
    - E1 samples lo. E2 is an index cycle (dummy, mem_addr=ZP_BASE|lo).
    - ea=ZP_BASE|((lo+index) mod 256); L=3.
    - Never sets page_cross.
  - ABS:
    - E1 samples lo, mem_addr<=pc_in+2.
    - E2 samples hi; ea={hi,lo}; L=3.
  - ABSX:
    - As ABS; base={hi,lo}; ea=base+index mod 2^16; page_cross=carry out of the low byte.
    - L=3 if !page_cross && !(is_write && IDX_WRITE_PENALTY), else L=4 (FIX cycle, mem_addr={hi,(lo+index)[7:0]}).
  - IND:
    - E1 lo, E2 hi: ptr={hi,lo}, mem_addr<=ptr.
    - E3 samples ea_lo; mem_addr<= INDIRECT_BUG ? {hi,lo+1 mod 256} : ptr+1.
    - E4 samples ea_hi; L=5.
  - INDX:
    - E1 samples lo.
    - E2: p=(lo+index) mod 256; mem_addr<=ZP_BASE|p.
    - E3 samples ea_lo; mem_addr<=ZP_BASE|((p+1) mod 256).
    - E4 samples ea_hi; L=5.
  - INDY:
    - E1 samples lo; mem_addr<=ZP_BASE|lo.
    - E2 samples b_lo; mem_addr<=ZP_BASE|((lo+1) mod 256).
    - E3 samples b_hi; ea={b_hi,b_lo}+index; page_cross as ABSX.
    - L=4, or 5 under the same penalty rule as ABSX.
- States: IDLE, OP_LO, OP_HI, IDX, PTR_LO, PTR_HI, FIX, DONE (the done cycle, which behaves as IDLE for acceptance).
- mem_addr holds its last value in IDLE. The unit never writes memory.

Test Plan:
- Memory {0x0200:0xB5, 0x0201:0xF0}, mode=ZPX, index=0x20, pc_in=0x0200 -> done after 3 edges; ea=0x0010; pc_next=0x0202; page_cross=0.
- Memory {0x0301:0xF0, 0x0302:0x12}, mode=ABSX, index=0x20, is_write=0 -> L=4, ea=0x1310, page_cross=1. Same with index=0x05 -> L=3, ea=0x12F5. Same with index=0x05 and is_write=1 -> L=4.
- IND with operand 0x10FF, mem[0x10FF]=0x34, mem[0x1000]=0x12, mem[0x1100]=0x56: with INDIRECT_BUG=1 -> ea=0x1234; with INDIRECT_BUG=0 -> ea=0x5634; L=5; pc_next=pc_in+3.
- INDX with lo=0xFE, index=0x01, mem[0x00FF]=0x00, mem[0x0000]=0x80 -> ea=0x8000 (zero-page wrap). INDY with lo=0xFF, mem[0x00FF]=0xFF, mem[0x0000]=0x10, index=0x01 -> ea=0x1100, page_cross=1, L=5.
- ZP_BASE=16'h4200, ZP operand 0x33 -> ea=0x4233. Back-to-back: second start issued in the done cycle is accepted, and mem_addr=new pc_in+1 on the next edge.
- Reset asserted at the E2 edge of an IND operation -> next cycle busy=0, done=0, ea=0, mem_addr=0. start while busy=1 causes no restart and leaves the latched mode unchanged.
